instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Owns the program counter and instruction register for the multi-cycle RV32I core.
- Drives the word address into the combinational instruction ROM and captures the returned word.
- Presents the captured instruction and its PC to the decode/control stage over a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and flags fetches that are misaligned or outside the ROM.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ROM_WORDS, 128, number of 32-bit words in the instruction ROM. A fetch at a PC with PC[31:2] >= ROM_WORDS faults.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. All state clears immediately on assertion; release is synchronous to clk.
- fetch_en  in  1  control-unit permission to fetch.
- rom_addr  out  32  byte address to the ROM. Always equal to pc.
- rom_data  in  32  ROM word, combinational from rom_addr.
- instr  out  32  instruction register.
- instr_pc  out  32  PC of the word in instr.
- instr_valid  out  1  instr/instr_pc hold an unconsumed instruction.
- instr_ready  in  1  consumer accepts the instruction this cycle.
- redirect_valid  in  1  load a new PC.
- redirect_pc  in  32  target PC.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  PC that caused the fault.
- fetch_count  out  32  number of IR loads. Wraps modulo 2^32.

## Operation
- States: FETCH, HOLD, FAULT.
- On reset:
  - pc = RESET_PC; state = FETCH.
  - instr, instr_pc, fault_pc, fetch_count = 0.
  - instr_valid, fault = 0.
- A PC is bad if pc[1:0] != 0 or pc[31:2] >= ROM_WORDS.
- A "load" means, in one edge:
  - instr <= rom_data; instr_pc <= pc; pc <= pc + 4 (32-bit wrap); fetch_count += 1; instr_valid <= 1; state <= HOLD.
- FETCH:
  - redirect_valid: pc <= redirect_pc; stay in FETCH; no load.
  - else fetch_en = 0: hold all state.
  - else bad PC: fault <= 1; fault_pc <= pc; instr_valid <= 0; state <= FAULT.
  - else: load.
- HOLD (instr_valid = 1):
  - redirect_valid has top priority: pc <= redirect_pc; instr_valid <= 0; state <= FETCH.
    - The held instruction is squashed if unaccepted. It counts as consumed if instr_ready is also high.
  - else instr_ready = 0: hold everything, including pc.
  - else instr_ready = 1 and fetch_en = 1 with a good PC: load, giving back-to-back throughput.
  - else instr_ready = 1 and fetch_en = 1 with a bad PC: enter FAULT as from FETCH.
  - else instr_ready = 1 and fetch_en = 0: instr_valid <= 0; state <= FETCH.
- FAULT:
  - instr_valid = 0; fault = 1.
  - redirect_valid, fetch_en and instr_ready are ignored.
  - Exits only through reset.
- While instr_valid = 1, instr and instr_pc must not change until the handshake completes or a redirect occurs.

## Timing
- ROM path is combinational: rom_addr = pc, and rom_data is sampled at the same edge.
- Fetch latency: the first edge after reset release with fetch_en = 1 gives instr_valid = 1, instr_pc = RESET_PC.
- Throughput: one instruction per cycle while instr_ready and fetch_en stay high.
- Redirect penalty:
  - Edge N: redirect sampled; instr_valid low after N.
  - Edge N+1: target loaded; earliest instr_pc = redirect_pc with instr_valid high after N+1.
- The fault flag rises one edge after the bad PC is present with a fetch attempt.
- Reset asserted mid-HOLD or in FAULT clears outputs without waiting for a clock edge.

## Test plan
- Back-to-back streaming:
  - Stimulus: release reset with fetch_en = 1, instr_ready = 1, ROM[1] = 32'h401102B3, ROM[2] = 32'h00210663.
  - Required: instr_pc = 0, 4, 8 on consecutive cycles; instr = 32'h401102B3 at pc 4; fetch_count = 3 after the third load.
- Backpressure:
  - Stimulus: hold instr_ready = 0 for 3 cycles while instr_pc = 8.
  - Required: instr = 32'h00210663 stable, instr_valid = 1, rom_addr = 12, fetch_count unchanged.
- Redirect during handshake:
  - Stimulus: instr_pc = 8, instr_ready = 1, redirect_valid = 1, redirect_pc = 32'h14.
  - Required: instr_valid = 0 for one cycle, then instr_pc = 32'h14.
- Misaligned redirect:
  - Stimulus: redirect_pc = 32'h6, then fetch_en = 1.
  - Required: fault = 1, fault_pc = 32'h6, instr_valid = 0; state held despite later redirects until reset.
- Out of range:
  - Stimulus: ROM_WORDS = 128, stream sequentially.
  - Required: after instr_pc = 32'h1FC, fault = 1 and fault_pc = 32'h200; fetch_count = 128.
- Async reset mid-HOLD:
  - Stimulus: assert reset between clock edges while instr_valid = 1.
  - Required: instr_valid, fault and fetch_count go to 0 and rom_addr goes to RESET_PC immediately.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM port, decode handshake, redirect input and status.
// Signal names match the core's top-level naming; master is the fetch unit.
interface instr_fetch_unit_if;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    input  fetch_en, rom_data, instr_ready, redirect_valid, redirect_pc,
    output rom_addr, instr, instr_pc, instr_valid, fault, fault_pc, fetch_count
  );

  modport slave (
    output fetch_en, rom_data, instr_ready, redirect_valid, redirect_pc,
    input  rom_addr, instr, instr_pc, instr_valid, fault, fault_pc, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch for the multi-cycle RV32I core: owns PC and IR, fetches from a
// combinational ROM, hands instructions to decode over valid/ready, traps bad PCs.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 128
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StFetch, StHold, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        pc_bad;
  logic        do_load;
  logic        do_fault;

  assign pc_bad = (pc_q[1:0] != 2'b00) || (32'(pc_q[31:2]) >= ROM_WORDS);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;
    do_load       = 1'b0;
    do_fault      = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end else if (bus.fetch_en) begin
          do_fault = pc_bad;
          do_load  = !pc_bad;
        end
      end
      StHold: begin
        // Redirect wins over everything; the held word is dropped either way.
        if (bus.redirect_valid) begin
          pc_d          = bus.redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = StFetch;
        end else if (bus.instr_ready) begin
          if (bus.fetch_en) begin
            do_fault = pc_bad;
            do_load  = !pc_bad;
          end else begin
            instr_valid_d = 1'b0;
            state_d       = StFetch;
          end
        end
      end
      StFault: ;
      default: state_d = StFault;
    endcase

    if (do_load) begin
      instr_d       = bus.rom_data;
      instr_pc_d    = pc_q;
      pc_d          = pc_q + 32'd4;
      fetch_count_d = fetch_count_q + 32'd1;
      instr_valid_d = 1'b1;
      state_d       = StHold;
    end

    if (do_fault) begin
      fault_d       = 1'b1;
      fault_pc_d    = pc_q;
      instr_valid_d = 1'b0;
      state_d       = StFault;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirects,
// misaligned and out-of-range faults, and asynchronous reset.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_WORDS(128)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    if (idx == 30'd1) return 32'h4011_02B3;
    if (idx == 30'd2) return 32'h0021_0663;
    if (idx < 30'd128) return 32'hA500_0000 | {2'b00, idx};
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    reset               = 1'b0;
    bus.fetch_en        = 1'b1;
    bus.instr_ready     = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;

    // Reset state
    step();
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_count", bus.fetch_count, 32'd0);
    check("rst_addr", bus.rom_addr, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_fault_pc", bus.fault_pc, 32'h0);

    // Back-to-back streaming
    reset = 1'b1;
    step();
    check("s0_valid", 32'(bus.instr_valid), 32'd1);
    check("s0_pc", bus.instr_pc, 32'h0);
    check("s0_instr", bus.instr, 32'hA500_0000);
    step();
    check("s1_pc", bus.instr_pc, 32'h4);
    check("s1_instr", bus.instr, 32'h4011_02B3);
    step();
    check("s2_pc", bus.instr_pc, 32'h8);
    check("s2_instr", bus.instr, 32'h0021_0663);
    check("s2_count", bus.fetch_count, 32'd3);

    // Backpressure
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_instr", bus.instr, 32'h0021_0663);
      check("bp_pc", bus.instr_pc, 32'h8);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_addr", bus.rom_addr, 32'hC);
      check("bp_count", bus.fetch_count, 32'd3);
    end

    // Redirect during handshake
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h14;
    step();
    check("rd_valid", 32'(bus.instr_valid), 32'd0);
    check("rd_addr", bus.rom_addr, 32'h14);
    check("rd_count", bus.fetch_count, 32'd3);
    bus.redirect_valid = 1'b0;
    step();
    check("rd_tgt_valid", 32'(bus.instr_valid), 32'd1);
    check("rd_tgt_pc", bus.instr_pc, 32'h14);
    check("rd_tgt_instr", bus.instr, 32'hA500_0005);
    check("rd_tgt_count", bus.fetch_count, 32'd4);

    // Accept with fetch_en low drops back to FETCH and idles
    bus.fetch_en = 1'b0;
    step();
    check("idle_valid", 32'(bus.instr_valid), 32'd0);
    check("idle_addr", bus.rom_addr, 32'h18);
    step();
    check("idle_count", bus.fetch_count, 32'd4);

    // Misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h6;
    step();
    check("mis_addr", bus.rom_addr, 32'h6);
    check("mis_fault_pre", 32'(bus.fault), 32'd0);
    bus.redirect_valid = 1'b0;
    bus.fetch_en       = 1'b1;
    step();
    check("mis_fault", 32'(bus.fault), 32'd1);
    check("mis_fault_pc", bus.fault_pc, 32'h6);
    check("mis_valid", 32'(bus.instr_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    repeat (2) step();
    check("mis_sticky", 32'(bus.fault), 32'd1);
    check("mis_sticky_addr", bus.rom_addr, 32'h6);
    check("mis_sticky_valid", 32'(bus.instr_valid), 32'd0);
    check("mis_sticky_count", bus.fetch_count, 32'd4);

    // Async reset out of FAULT, between edges
    #2 reset = 1'b0;
    #1;
    check("arf_fault", 32'(bus.fault), 32'd0);
    check("arf_addr", bus.rom_addr, 32'h0);
    check("arf_count", bus.fetch_count, 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    reset = 1'b1;

    // Async reset mid-HOLD
    bus.instr_ready = 1'b0;
    step();
    check("arh_pre_valid", 32'(bus.instr_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arh_valid", 32'(bus.instr_valid), 32'd0);
    check("arh_fault", 32'(bus.fault), 32'd0);
    check("arh_count", bus.fetch_count, 32'd0);
    check("arh_addr", bus.rom_addr, 32'h0);
    step();

    // Out of range: stream the whole ROM
    bus.instr_ready = 1'b1;
    reset           = 1'b1;
    step();
    check("oor_first_pc", bus.instr_pc, 32'h0);
    repeat (127) step();
    check("oor_last_pc", bus.instr_pc, 32'h1FC);
    check("oor_last_valid", 32'(bus.instr_valid), 32'd1);
    check("oor_last_count", bus.fetch_count, 32'd128);
    step();
    check("oor_fault", 32'(bus.fault), 32'd1);
    check("oor_fault_pc", bus.fault_pc, 32'h200);
    check("oor_valid", 32'(bus.instr_valid), 32'd0);
    check("oor_count", bus.fetch_count, 32'd128);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
